// File: rtl/regfile_init_arb_if.sv
// Register-file write-port bundle between the init/arbiter block and its environment.
// The master side drives the requests; the slave side (the arbiter) drives the write port and status.
interface regfile_init_arb_if;
  logic        reinit;
  logic        init_req;
  logic [4:0]  init_idx;
  logic [31:0] init_data;
  logic        init_valid;
  logic        wb_we;
  logic [4:0]  wb_wr;
  logic [31:0] wb_wd;
  logic        dbg_req;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_gnt;
  logic        rf_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic        cpu_hold;
  logic        init_done;

  modport master (
    output reinit, init_data, init_valid,
    output wb_we, wb_wr, wb_wd,
    output dbg_req, dbg_addr, dbg_data,
    input  init_req, init_idx, dbg_gnt,
    input  rf_we, rf_wr, rf_wd, cpu_hold, init_done
  );

  modport slave (
    input  reinit, init_data, init_valid,
    input  wb_we, wb_wr, wb_wd,
    input  dbg_req, dbg_addr, dbg_data,
    output init_req, init_idx, dbg_gnt,
    output rf_we, rf_wr, rf_wd, cpu_hold, init_done
  );
endinterface

// File: rtl/regfile_init_arb.sv
// Loads x1..x31 after reset/reinit, then arbitrates the single RF write port between WB and debug.
// Zero-latency write mux; a starved debug request freezes the pipeline for one cycle to get through.
module regfile_init_arb #(
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              clk_50,
  input  logic              rst_i,
  regfile_init_arb_if.slave bus
);

  localparam int unsigned SW = ($clog2(STARVE_LIM + 1) > 3) ? $clog2(STARVE_LIM + 1) : 3;
  localparam logic [SW-1:0] LIM       = SW'(STARVE_LIM);
  localparam logic [4:0]    FIRST_IDX = 5'd1;
  localparam logic [4:0]    LAST_IDX  = 5'd31;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FORCE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [SW-1:0] starve_q, starve_d;

  state_e        state_cur;
  logic [4:0]    idx_cur;
  logic          wb_hit;

  logic          init_req_o;
  logic [4:0]    init_idx_o;
  logic          dbg_gnt_o;
  logic          rf_we_o;
  logic [4:0]    rf_wr_o;
  logic [31:0]   rf_wd_o;
  logic          cpu_hold_o;
  logic          init_done_o;

  assign wb_hit = bus.wb_we && (bus.wb_wr != 5'd0);

  always_comb begin
    // Reset is folded in combinationally so the outputs look like INIT while rst_i is high.
    state_cur   = rst_i ? INIT : state_q;
    idx_cur     = rst_i ? FIRST_IDX : idx_q;

    state_d     = state_cur;
    idx_d       = idx_cur;
    starve_d    = starve_q;

    init_req_o  = 1'b0;
    init_idx_o  = 5'd0;
    dbg_gnt_o   = 1'b0;
    rf_we_o     = 1'b0;
    rf_wr_o     = 5'd0;
    rf_wd_o     = 32'd0;
    cpu_hold_o  = 1'b0;
    init_done_o = 1'b0;

    unique case (state_cur)
      INIT: begin
        init_req_o = 1'b1;
        init_idx_o = idx_cur;
        cpu_hold_o = 1'b1;
        starve_d   = '0;
        if (bus.init_valid) begin
          rf_we_o = 1'b1;
          rf_wr_o = idx_cur;
          rf_wd_o = bus.init_data;
          if (idx_cur == LAST_IDX) begin
            state_d = RUN;
            idx_d   = FIRST_IDX;
          end else begin
            idx_d = idx_cur + 5'd1;
          end
        end
        if (bus.reinit) begin
          state_d = INIT;
          idx_d   = FIRST_IDX;
        end
      end

      RUN: begin
        init_done_o = 1'b1;
        if (wb_hit) begin
          rf_we_o = 1'b1;
          rf_wr_o = bus.wb_wr;
          rf_wd_o = bus.wb_wd;
        end else if (bus.dbg_req) begin
          // A debug write to x0 is acknowledged but never reaches the file.
          dbg_gnt_o = 1'b1;
          if (bus.dbg_addr != 5'd0) begin
            rf_we_o = 1'b1;
            rf_wr_o = bus.dbg_addr;
            rf_wd_o = bus.dbg_data;
          end
        end
        if (bus.dbg_req && !dbg_gnt_o) begin
          starve_d = starve_q + 1'b1;
          if (starve_d == LIM) begin
            state_d = FORCE;
          end
        end else begin
          starve_d = '0;
        end
      end

      FORCE: begin
        init_done_o = 1'b1;
        cpu_hold_o  = 1'b1;
        if (bus.dbg_req) begin
          dbg_gnt_o = 1'b1;
          if (bus.dbg_addr != 5'd0) begin
            rf_we_o = 1'b1;
            rf_wr_o = bus.dbg_addr;
            rf_wd_o = bus.dbg_data;
          end
        end
        state_d  = RUN;
        starve_d = '0;
      end

      default: begin
        state_d  = INIT;
        idx_d    = FIRST_IDX;
        starve_d = '0;
      end
    endcase

    if ((state_cur != INIT) && bus.reinit) begin
      state_d  = INIT;
      idx_d    = FIRST_IDX;
      starve_d = '0;
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst_i) begin
      state_q  <= INIT;
      idx_q    <= FIRST_IDX;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      starve_q <= starve_d;
    end
  end

  assign bus.init_req  = init_req_o;
  assign bus.init_idx  = init_idx_o;
  assign bus.dbg_gnt   = dbg_gnt_o;
  assign bus.rf_we     = rf_we_o;
  assign bus.rf_wr     = rf_wr_o;
  assign bus.rf_wd     = rf_wd_o;
  assign bus.cpu_hold  = cpu_hold_o;
  assign bus.init_done = init_done_o;

endmodule

// File: tb/tb_regfile_init_arb.sv
// Scoreboard bench: a cycle-level reference model queues the expected outputs; a negedge monitor checks them.
module tb_regfile_init_arb;
  localparam int LIM = 4;

  logic clk_50 = 1'b0;
  logic rst_i;
  always #10 clk_50 = ~clk_50;

  regfile_init_arb_if bus();

  regfile_init_arb #(.STARVE_LIM(LIM)) dut (
    .clk_50 (clk_50),
    .rst_i  (rst_i),
    .bus    (bus)
  );

  typedef struct packed {
    logic        init_req;
    logic [4:0]  init_idx;
    logic        cpu_hold;
    logic        init_done;
    logic        dbg_gnt;
    logic        rf_we;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd;
  } obs_t;

  obs_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   cyc_no   = 0;
  bit   final_req  = 1'b0;
  bit   final_done = 1'b0;

  // reference model: "still loading, next index" / "denied streak" / "frozen this cycle"
  bit          m_init;
  int          m_next;
  int          m_denied;
  bit          m_forced;
  logic [31:0] m_rf [32];
  logic [31:0] d_rf [32];

  // stimulus for the next cycle; debug request is held until granted
  bit          s_rst, s_reinit, s_iv, s_wwe;
  logic [31:0] s_idata, s_wwd;
  logic [4:0]  s_wwr;
  bit          dp;
  logic [4:0]  da;
  logic [31:0] dd;

  task automatic idle_in();
    s_rst = 0; s_reinit = 0; s_iv = 0; s_wwe = 0;
    s_idata = '0; s_wwd = '0; s_wwr = '0;
  endtask

  task automatic cyc();
    obs_t e;
    int   idx;
    rst_i          = s_rst;
    bus.reinit     = s_reinit;
    bus.init_valid = s_iv;
    bus.init_data  = s_idata;
    bus.wb_we      = s_wwe;
    bus.wb_wr      = s_wwr;
    bus.wb_wd      = s_wwd;
    bus.dbg_req    = dp;
    bus.dbg_addr   = da;
    bus.dbg_data   = dd;

    e = '0;
    if (s_rst || m_init) begin
      idx = s_rst ? 1 : m_next;
      e.init_req = 1; e.init_idx = 5'(idx); e.cpu_hold = 1;
      if (s_iv) begin e.rf_we = 1; e.rf_wr = 5'(idx); e.rf_wd = s_idata; end
    end else begin
      e.init_done = 1;
      e.cpu_hold  = m_forced;
      if (!m_forced && s_wwe && s_wwr != 0) begin
        e.rf_we = 1; e.rf_wr = s_wwr; e.rf_wd = s_wwd;
      end else if (dp) begin
        e.dbg_gnt = 1;
        if (da != 0) begin e.rf_we = 1; e.rf_wr = da; e.rf_wd = dd; end
      end
    end
    exp_q.push_back(e);
    if (e.rf_we) m_rf[e.rf_wr] = e.rf_wd;

    if (s_rst) begin
      m_init = 1; m_next = 1; m_denied = 0; m_forced = 0;
    end else if (m_init) begin
      if (s_reinit) m_next = 1;
      else if (s_iv) begin
        if (m_next == 31) begin m_init = 0; m_denied = 0; m_forced = 0; end
        else m_next++;
      end
    end else if (s_reinit) begin
      m_init = 1; m_next = 1; m_denied = 0; m_forced = 0;
    end else if (m_forced) begin
      m_forced = 0; m_denied = 0;
    end else begin
      if (dp && !e.dbg_gnt) m_denied++;
      else m_denied = 0;
      if (m_denied == LIM) begin m_forced = 1; m_denied = 0; end
    end

    if (e.dbg_gnt) dp = 0;
    @(posedge clk_50); #1;
  endtask

  task automatic rnd(int n, int reinit_1in, int rst_1in);
    repeat (n) begin
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1;
        da = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        dd = $urandom;
      end
      s_rst    = (rst_1in > 0) && ($urandom_range(1, rst_1in) == 1);
      s_reinit = (reinit_1in > 0) && ($urandom_range(1, reinit_1in) == 1);
      s_iv     = $urandom_range(0, 1) == 1;
      s_idata  = $urandom;
      s_wwe    = $urandom_range(0, 3) != 0;
      s_wwr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      s_wwd    = $urandom;
      cyc();
    end
    idle_in();
  endtask

  always @(negedge clk_50) begin
    obs_t act, ex;
    cyc_no++;
    if (exp_q.size() > 0) begin
      ex  = exp_q.pop_front();
      act = {bus.init_req, bus.init_idx, bus.cpu_hold, bus.init_done,
             bus.dbg_gnt, bus.rf_we, bus.rf_wr, bus.rf_wd};
      chk_cnt++;
      if (act === ex) pass_cnt++;
      else $display("FAIL outputs @%0d: got req=%b idx=%0d hold=%b done=%b gnt=%b we=%b wr=%0d wd=%h, need req=%b idx=%0d hold=%b done=%b gnt=%b we=%b wr=%0d wd=%h",
                    cyc_no, act.init_req, act.init_idx, act.cpu_hold, act.init_done, act.dbg_gnt,
                    act.rf_we, act.rf_wr, act.rf_wd, ex.init_req, ex.init_idx, ex.cpu_hold,
                    ex.init_done, ex.dbg_gnt, ex.rf_we, ex.rf_wr, ex.rf_wd);
      if (act.rf_we === 1'b1) d_rf[act.rf_wr] = act.rf_wd;
    end else if (final_req && !final_done) begin
      for (int i = 0; i < 32; i++) begin
        chk_cnt++;
        if (d_rf[i] === m_rf[i]) pass_cnt++;
        else $display("FAIL regfile x%0d: got %h need %h", i, d_rf[i], m_rf[i]);
      end
      final_done = 1;
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; d_rf[i] = '0; end
    m_init = 1; m_next = 1; m_denied = 0; m_forced = 0;
    dp = 0; da = '0; dd = '0;
    idle_in();
    rst_i = 1; bus.reinit = 0; bus.init_valid = 0; bus.init_data = '0;
    bus.wb_we = 0; bus.wb_wr = '0; bus.wb_wd = '0;
    bus.dbg_req = 0; bus.dbg_addr = '0; bus.dbg_data = '0;
    @(posedge clk_50); #1;

    // reset with random init_valid
    repeat (3) begin s_rst = 1; s_iv = $urandom_range(0, 1) == 1; s_idata = $urandom; cyc(); end
    idle_in();

    // back-to-back init words idx*0x11; WB activity is ignored while loading
    for (int i = 0; i < 31; i++) begin
      s_iv = 1; s_idata = 32'(m_next * 'h11);
      s_wwe = 1; s_wwr = 5'($urandom_range(1, 31)); s_wwd = $urandom;
      cyc();
    end
    idle_in();
    cyc();

    // WB wins, debug goes next cycle
    dp = 1; da = 5'd7; dd = 32'hBEEF;
    s_wwe = 1; s_wwr = 5'd5; s_wwd = 32'hDEAD; cyc();
    idle_in(); cyc();

    // continuous WB starves debug until a forced cycle
    dp = 1; da = 5'd9; dd = 32'h1234;
    repeat (8) begin s_wwe = 1; s_wwr = 5'd3; s_wwd = $urandom; cyc(); end
    idle_in();

    // writes to x0 from either source
    s_wwe = 1; s_wwr = 5'd0; s_wwd = 32'hFFFF_FFFF; cyc();
    idle_in();
    dp = 1; da = 5'd0; dd = 32'hCAFE; cyc();
    cyc();

    rnd(200, 60, 0);

    // reinit in RUN, then gapped init with a debug request pending throughout
    guard = 0;
    while (m_init && guard < 100) begin s_iv = 1; s_idata = $urandom; cyc(); guard++; end
    idle_in();
    s_reinit = 1; s_wwe = 1; s_wwr = 5'd4; s_wwd = 32'h4444; cyc();
    idle_in();
    dp = 1; da = 5'd12; dd = 32'h0C0C;
    guard = 0;
    while (m_init && guard < 100) begin
      s_iv = guard[0]; s_idata = $urandom; cyc(); guard++;
    end
    idle_in();
    cyc(); cyc();

    // reset in the middle of loading
    s_reinit = 1; cyc(); idle_in();
    guard = 0;
    while (m_next != 17 && guard < 100) begin s_iv = 1; s_idata = $urandom; cyc(); guard++; end
    s_rst = 1; s_iv = 1; s_idata = $urandom; cyc();
    idle_in();
    guard = 0;
    while (m_init && guard < 200) begin s_iv = $urandom_range(0, 1) == 1; s_idata = $urandom; cyc(); guard++; end
    idle_in();

    rnd(300, 80, 120);

    idle_in();
    dp = 0;
    cyc(); cyc();
    final_req = 1;
    for (int i = 0; i < 20 && !final_done; i++) @(negedge clk_50);
    if (!final_done) begin
      $display("FAIL drain: scoreboard still holds %0d entries, need 0", exp_q.size());
      $fatal(1);
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
